// File: rtl/spi_master.sv
// SPI master (mode 0, MSB first) for framed command + data transactions.
// Each frame shifts out an N-bit word {cmd, data} while shifting N bits of
// miso into a receive register. The received word is published on
// rx_stat/rx_data together with a one-cycle done pulse when ncs rises.
//
// Handshake: start is accepted only in IDLE (busy=0). busy stays high from
// the accepting edge through the post-frame gap; start while busy is dropped.
module spi_master #(
    parameter int CLK_DIV = 4,
    parameter int CMD_W   = 8,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic [CMD_W-1:0]  tx_cmd,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [CMD_W-1:0]  rx_stat,
    output logic [DATA_W-1:0] rx_data,
    output logic              sck,
    output logic              mosi,
    output logic              ncs,
    input  logic              miso
);

    localparam int N     = CMD_W + DATA_W;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(N) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t             state;
    logic [DIV_W-1:0]   div_cnt;
    logic [BIT_W-1:0]   bit_cnt;
    logic [N-1:0]       tx_sr;
    logic [N-1:0]       rx_sr;
    logic               div_last;

    // Every non-idle phase lasts exactly CLK_DIV clk cycles.
    assign div_last = (div_cnt == DIV_W'(CLK_DIV - 1));

    // mosi is the MSB of the transmit register; clearing the register at the
    // end of the frame returns the line to 0 without a separate mosi flop.
    assign mosi = tx_sr[N-1];

    // Frame sequencer: owns all registered outputs and both shift registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sr   <= '0;
            rx_sr   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sck     <= 1'b0;
            ncs     <= 1'b1;
            rx_stat <= '0;
            rx_data <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        tx_sr   <= {tx_cmd, tx_data};
                        ncs     <= 1'b0;
                        busy    <= 1'b1;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= LOW;
                    end
                end
                LOW: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sck     <= 1'b1;
                        rx_sr   <= {rx_sr[N-2:0], miso};
                        state   <= HIGH;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        sck     <= 1'b0;
                        if (bit_cnt == BIT_W'(N - 1)) begin
                            state <= HOLD;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx_sr   <= tx_sr << 1;
                            state   <= LOW;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        ncs     <= 1'b1;
                        tx_sr   <= '0;
                        done    <= 1'b1;
                        rx_stat <= rx_sr[N-1:DATA_W];
                        rx_data <= rx_sr[DATA_W-1:0];
                        state   <= GAP;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: one instance at the default divider
// (loopback or slave-model miso) and one at CLK_DIV=1 (loopback).
module tb_spi_master;

    localparam int CMD_W  = 8;
    localparam int DATA_W = 32;
    localparam int N      = CMD_W + DATA_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic nrst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT 0 (CLK_DIV=4) ----------------
    logic              start0;
    logic [CMD_W-1:0]  tx_cmd0;
    logic [DATA_W-1:0] tx_data0;
    logic              busy0, done0, sck0, mosi0, ncs0, miso0;
    logic [CMD_W-1:0]  rx_stat0;
    logic [DATA_W-1:0] rx_data0;

    // ---------------- DUT 1 (CLK_DIV=1) ----------------
    logic              start1;
    logic [CMD_W-1:0]  tx_cmd1;
    logic [DATA_W-1:0] tx_data1;
    logic              busy1, done1, sck1, mosi1, ncs1, miso1;
    logic [CMD_W-1:0]  rx_stat1;
    logic [DATA_W-1:0] rx_data1;

    logic loopback = 1'b1;
    logic slave_miso = 1'b0;
    logic [N-1:0] slave_reply = '0;
    logic [N-1:0] slave_tx = '0;
    logic [N-1:0] slave_rx = '0;

    assign miso0 = loopback ? mosi0 : slave_miso;
    assign miso1 = mosi1;

    spi_master #(.CLK_DIV(4), .CMD_W(CMD_W), .DATA_W(DATA_W)) dut0 (
        .clk(clk), .nrst(nrst), .start(start0), .tx_cmd(tx_cmd0), .tx_data(tx_data0),
        .busy(busy0), .done(done0), .rx_stat(rx_stat0), .rx_data(rx_data0),
        .sck(sck0), .mosi(mosi0), .ncs(ncs0), .miso(miso0)
    );

    spi_master #(.CLK_DIV(1), .CMD_W(CMD_W), .DATA_W(DATA_W)) dut1 (
        .clk(clk), .nrst(nrst), .start(start1), .tx_cmd(tx_cmd1), .tx_data(tx_data1),
        .busy(busy1), .done(done1), .rx_stat(rx_stat1), .rx_data(rx_data1),
        .sck(sck1), .mosi(mosi1), .ncs(ncs1), .miso(miso1)
    );

    // ---------------- mode-0 slave model on DUT 0 ----------------
    always @(negedge ncs0) begin
        slave_tx   = slave_reply;
        slave_miso = slave_tx[N-1];
        slave_rx   = '0;
    end

    always @(negedge sck0) begin
        if (!ncs0) begin
            slave_tx   = slave_tx << 1;
            slave_miso = slave_tx[N-1];
        end
    end

    always @(posedge sck0) begin
        if (!ncs0) slave_rx = {slave_rx[N-2:0], mosi0};
    end

    // ---------------- scoreboard ----------------
    logic [N-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sb_pop(input string tag, input logic [N-1:0] got);
        if (exp_q.size() == 0) check({tag, "_unexpected_done"}, 64'd1, 64'd0);
        else check(tag, got, exp_q.pop_front());
    endtask

    always @(negedge clk) begin
        if (nrst && done0 === 1'b1) sb_pop("rx_div4", {rx_stat0, rx_data0});
        if (nrst && done1 === 1'b1) sb_pop("rx_div1", {rx_stat1, rx_data1});
    end

    // ---------------- driver tasks ----------------
    // One full frame on DUT 0 with timing checks; called right after a negedge.
    task automatic run_frame(input logic [CMD_W-1:0] cmd, input logic [DATA_W-1:0] data,
                             input logic [N-1:0] expv, input int pa, input int pb,
                             input string tag);
        int rises, rise_err, mosi_err, done_cnt, done_k, ncs_k, busy_k;
        logic psck, pmosi;
        rises = 0; rise_err = 0; mosi_err = 0; done_cnt = 0;
        done_k = -1; ncs_k = -1; busy_k = -1;
        psck = 1'b0; pmosi = 1'b0;
        tx_cmd0 = cmd; tx_data0 = data; start0 = 1'b1;
        exp_q.push_back(expv);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tx_cmd0  = CMD_W'($urandom);
                tx_data0 = DATA_W'($urandom);
                check({tag, "_accept"}, {61'd0, ncs0, busy0, mosi0}, {61'd0, 1'b0, 1'b1, cmd[CMD_W-1]});
            end
            start0 = (k == pa || k == pb);
            if (sck0 && !psck) begin
                rises++;
                if (k % 8 != 4) rise_err++;
                if (mosi0 !== pmosi) mosi_err++;
            end
            if (done0) begin done_cnt++; done_k = k; end
            if (ncs0 && ncs_k < 0) ncs_k = k;
            psck = sck0; pmosi = mosi0;
            if (!busy0) begin busy_k = k; break; end
        end
        start0 = 1'b0;
        check({tag, "_sck_rises"}, 64'(rises), 64'd40);
        check({tag, "_sck_rise_pos_err"}, 64'(rise_err), 64'd0);
        check({tag, "_mosi_stable_err"}, 64'(mosi_err), 64'd0);
        check({tag, "_ncs_rise_cycle"}, 64'(ncs_k), 64'd324);
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_done_cycle"}, 64'(done_k), 64'd324);
        check({tag, "_busy_fall_cycle"}, 64'(busy_k), 64'd328);
        repeat (3) @(negedge clk);
        check({tag, "_idle_after"}, {62'd0, ncs0, busy0}, {62'd0, 1'b1, 1'b0});
    endtask

    // ---------------- main sequence ----------------
    logic [CMD_W-1:0]  rc;
    logic [DATA_W-1:0] rd;
    int saw_done, hi_run, gap, seen_low, dones1, rises1;
    logic psck1;

    initial begin
        start0 = 1'b0; tx_cmd0 = '0; tx_data0 = '0;
        start1 = 1'b0; tx_cmd1 = '0; tx_data1 = '0;

        // Reset with random inputs for 3 cycles
        nrst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            start0 = 1'($urandom); tx_cmd0 = CMD_W'($urandom); tx_data0 = DATA_W'($urandom);
            start1 = 1'($urandom); tx_cmd1 = CMD_W'($urandom); tx_data1 = DATA_W'($urandom);
        end
        @(negedge clk);
        check("reset_ctrl0", {59'd0, ncs0, sck0, mosi0, busy0, done0}, 64'b10000);
        check("reset_rx0", {24'd0, rx_stat0, rx_data0}, 64'd0);
        check("reset_ctrl1", {59'd0, ncs1, sck1, mosi1, busy1, done1}, 64'b10000);
        check("reset_rx1", {24'd0, rx_stat1, rx_data1}, 64'd0);
        start0 = 1'b0; start1 = 1'b0;
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // Loopback with ignored start pulses during the frame
        loopback = 1'b1;
        run_frame(8'hA0, 32'h24AF55AA, {8'hA0, 32'h24AF55AA}, 50, 326, "loop");
        check("loop_hold_stat", {56'd0, rx_stat0}, 64'hA0);

        // Slave model reply
        loopback = 1'b0;
        slave_reply = {8'h5C, 32'hDEADBEEF};
        run_frame(8'h51, 32'h01234567, {8'h5C, 32'hDEADBEEF}, -1, -1, "slave");
        check("slave_decode", {24'd0, slave_rx}, {24'd0, 8'h51, 32'h01234567});

        // Random loopback frame
        loopback = 1'b1;
        rc = CMD_W'($urandom); rd = DATA_W'($urandom);
        run_frame(rc, rd, {rc, rd}, -1, -1, "rand");

        // Reset mid-frame
        saw_done = 0;
        tx_cmd0 = 8'h3C; tx_data0 = 32'h0F0F0F0F; start0 = 1'b1;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            start0 = 1'b0;
            if (done0) saw_done++;
        end
        nrst = 1'b0;
        @(negedge clk);
        check("abort_ctrl", {59'd0, ncs0, sck0, mosi0, busy0, done0}, 64'b10000);
        check("abort_rx", {24'd0, rx_stat0, rx_data0}, 64'd0);
        check("abort_no_done", 64'(saw_done), 64'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(8'hC3, 32'h89ABCDEF, {8'hC3, 32'h89ABCDEF}, -1, -1, "post_abort");

        // CLK_DIV=1, start held high: two back-to-back loopback frames
        hi_run = 0; gap = -1; seen_low = 0; dones1 = 0; rises1 = 0; psck1 = 1'b0;
        tx_cmd1 = 8'h96; tx_data1 = 32'h13579BDF; start1 = 1'b1;
        exp_q.push_back({8'h96, 32'h13579BDF});
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (k == 0) begin
                tx_cmd1 = 8'h6A; tx_data1 = 32'hFEDCBA98;
                exp_q.push_back({8'h6A, 32'hFEDCBA98});
            end
            if (sck1 && !psck1) rises1++;
            psck1 = sck1;
            if (done1) dones1++;
            if (ncs1) hi_run++;
            else begin
                if (seen_low != 0 && hi_run > 0) gap = hi_run;
                hi_run = 0;
                seen_low = 1;
            end
            if (dones1 == 2) start1 = 1'b0;
            if (dones1 == 2 && !busy1) break;
        end
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        check("div1_dones", 64'(dones1), 64'd2);
        check("div1_ncs_gap", 64'(gap), 64'd2);
        check("div1_sck_rises", 64'(rises1), 64'd80);
        check("div1_idle_after", {62'd0, ncs1, busy1}, {62'd0, 1'b1, 1'b0});

        check("sb_drain", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global time bound
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- FPGA-side SPI master that generates the framed transaction consumed by spi_module: sck, mosi and ncs, with miso captured.
- Each transaction is a CMD_W-bit command followed by a DATA_W-bit data word, MSB first, SPI mode 0.
- A start/busy/done handshake lets local control logic or a sequencer issue register writes and status reads to spi_module or an external slave.

Parameters:
- CLK_DIV, 4: clk cycles per sck half-period; legal range ≥1.
- CMD_W, 8: command field width in bits.
- DATA_W, 32: data field width in bits.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- nrst  in  1  synchronous active-low reset.
- start  in  1  request a transaction; sampled only when busy=0.
- tx_cmd  in  CMD_W  command to send; latched at start.
- tx_data  in  DATA_W  data to send; latched at start.
- busy  out  1  high from the accepting edge until the end of the gap.
- done  out  1  one-cycle pulse when ncs rises; rx outputs are valid from this cycle.
- rx_stat  out  CMD_W  bits received during the command field.
- rx_data  out  DATA_W  bits received during the data field.
- sck  out  1  SPI clock; idles low.
- mosi  out  1  serial data out.
- ncs  out  1  active-low chip select.
- miso  in  1  serial data in; assumed stable at sck rising edges.

Behaviour:
- Reset (nrst=0 at a clk edge):
  - ncs=1, sck=0, mosi=0, busy=0, done=0, rx_stat=0, rx_data=0.
  - State returns to IDLE and the bit and divide counters clear.
  - Applies mid-transaction: the frame is aborted, no done pulse, rx outputs cleared.
- Definitions: N = CMD_W+DATA_W. Cycle 0 is the edge where start=1 is sampled in IDLE.
- States:
  - IDLE: ncs=1, sck=0, mosi=0. On start, load {tx_cmd,tx_data} into an N-bit tx shift register, go to LOW.
  - LOW: at cycle 0 edge, ncs=0, busy=1, mosi=tx_cmd[CMD_W-1], sck=0. Wait CLK_DIV cycles, then go to HIGH.
  - HIGH: on entering, sck=1 and miso is shifted into the LSB of an N-bit rx shift register on that same edge. Wait CLK_DIV cycles. Then sck=0, and either:
    - bits remain: tx register shifts left, mosi takes the next bit, return to LOW; or
    - last bit done: go to HOLD.
  - HOLD: sck=0, ncs=0, mosi keeps the last bit, for CLK_DIV cycles. At the exit edge:
    - ncs=1, mosi=0, done=1;
    - rx_stat = rx register [N-1:DATA_W], rx_data = rx register [DATA_W-1:0];
    - go to GAP.
  - GAP: ncs=1, done=0, busy=1 for CLK_DIV cycles, then busy=0 and go to IDLE.
- Timing for bit n (0..N-1):
  - sck rises at cycle CLK_DIV·(2n+1) and falls at CLK_DIV·(2n+2).
  - ncs rises and done pulses at CLK_DIV·(2N+1).
  - busy falls at CLK_DIV·(2N+2).
  - Defaults: sck rises at 4, 12, …, 316; ncs rises at 324; busy falls at 328.
- mosi changes only on the edge where sck falls (and at frame start). It never changes on an sck rising edge.
- Handshake:
  - start while busy=1 is ignored; there is no queueing.
  - With start held high continuously, the next frame is accepted on the first edge after busy falls. ncs then stays high for CLK_DIV+1 cycles between frames.
- Data capture: tx_cmd and tx_data may change after the accepting edge without affecting the frame in flight.
- rx_stat and rx_data hold their values until the next done or reset. They never show partial data.
- Counters:
  - divide counter width clog2(CLK_DIV)+1; bit counter width clog2(N)+1.
  - CLK_DIV=1 must work: sck toggles every clk cycle.

Test Plan:
- Reset: hold nrst=0 for 3 cycles with random inputs → ncs=1, sck=0, mosi=0, busy=0, done=0, rx_stat=0, rx_data=0.
- Loopback (miso tied to mosi), tx_cmd=A0, tx_data=24AF55AA, defaults → 40 sck rising edges at cycles 4+8k; ncs low over cycles 0–323; done at 324 only; rx_stat=A0, rx_data=24AF55AA; busy falls at 328.
- Slave model returns 5C then DEADBEEF for tx_cmd=51, tx_data=01234567 → the slave decodes cmd 51 and data 01234567; rx_stat=5C, rx_data=DEADBEEF; mosi is stable across every sck rising edge.
- start pulsed at cycles 50 and 326 during a frame → ignored; exactly one done; sck edge count = 40.
- nrst=0 at cycle 100 mid-frame → next edge gives ncs=1, sck=0, busy=0, no done, rx outputs 0; a new start afterwards completes normally.
- CLK_DIV=1 with start held high → back-to-back frames; ncs high for exactly 2 cycles between frames; loopback data correct in both frames.
